// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported unified memory between the instruction-fetch
//   requester (IF) and the load/store requester (DM). A winning request is
//   latched, issued for one cycle, held while the memory latency elapses,
//   and the read word is returned in a registered rdata with a 1-cycle
//   rvalid pulse. Back-to-back accesses chain RESP -> ISSUE directly.
//
//   Optional build macro: ARB_RR_EN
//     defined   : contended arbitration alternates (DM first after reset)
//     undefined : fixed DM priority, no history register
//
// Ports
//   clock, reset             rising-edge clock, async active-high reset
//   if_req/if_addr           fetch request (level) and address
//   if_gnt/if_rvalid/if_rdata  fetch issued pulse, data valid pulse, data
//   dm_req/dm_we/dm_addr/dm_wdata  load/store request, direction, addr, data
//   dm_gnt/dm_rvalid/dm_rdata  data issued pulse, done pulse, load data
//   mem_addr/mem_we/mem_wdata  memory address, write strobe, write data
//   mem_rdata                memory read data, valid MEM_LAT cycles after issue
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int              CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                owner_dm_q, owner_dm_d;
    logic                we_q, we_d;
    // mem_addr/mem_wdata registers double as the request latch: they are
    // loaded at sampling and held until the next sampling.
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_we_q, mem_we_d;
    logic                if_gnt_q, if_gnt_d;
    logic                dm_gnt_q, dm_gnt_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic                dm_rvalid_q, dm_rvalid_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
    logic                pick_dm_s;
    logic                any_req_s;

    assign any_req_s = if_req | dm_req;

`ifdef ARB_RR_EN
    logic rr_last_dm_q, rr_last_dm_d;
    logic contend_s;

    assign contend_s = if_req & dm_req;
    // On contention DM wins unless it won the previous contended round.
    assign pick_dm_s = dm_req & (~if_req | ~rr_last_dm_q);

    // Contended-arbitration history; reset value lets DM win first.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_last_dm_q <= 1'b0;
        end else begin
            rr_last_dm_q <= rr_last_dm_d;
        end
    end
`else
    assign pick_dm_s = dm_req;
`endif

    // Next-state and registered-output computation for the access sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_dm_d  = owner_dm_q;
        we_d        = we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        if_gnt_d    = 1'b0;
        dm_gnt_d    = 1'b0;
        if_rvalid_d = 1'b0;
        dm_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
`ifdef ARB_RR_EN
        rr_last_dm_d = rr_last_dm_q;
`endif
        case (state_q)
            S_IDLE, S_RESP: begin
                if (any_req_s) begin
                    // Latch the winner; gnt and mem_we are registered so they
                    // appear exactly during the ISSUE cycle.
                    state_d    = S_ISSUE;
                    owner_dm_d = pick_dm_s;
                    if (pick_dm_s) begin
                        we_d        = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                        mem_we_d    = dm_we;
                        dm_gnt_d    = 1'b1;
                    end else begin
                        we_d        = 1'b0;
                        mem_addr_d  = if_addr;
                        if_gnt_d    = 1'b1;
                    end
`ifdef ARB_RR_EN
                    if (contend_s) begin
                        rr_last_dm_d = pick_dm_s;
                    end else begin
                        rr_last_dm_d = rr_last_dm_q;
                    end
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = CNT_LOAD;
            end
            S_WAIT: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = S_RESP;
                    if (owner_dm_q) begin
                        dm_rvalid_d = 1'b1;
                        if (!we_q) begin
                            dm_rdata_d = mem_rdata;
                        end else begin
                            dm_rdata_d = dm_rdata_q;
                        end
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            owner_dm_q  <= 1'b0;
            we_q        <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            mem_we_q    <= 1'b0;
            if_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata_q  <= {DATA_W{1'b0}};
            dm_rdata_q  <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_dm_q  <= owner_dm_d;
            we_q        <= we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            if_gnt_q    <= if_gnt_d;
            dm_gnt_q    <= dm_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_gnt    = dm_gnt_q;
    assign dm_rvalid = dm_rvalid_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Bench for mem_port_arbiter. u_dut1 (MEM_LAT=1) runs a vector table and
//   reset/arbitration sequences against a grant/response scoreboard;
//   u_dut3 (MEM_LAT=3) covers the long-latency capture case.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    always #5 clock = ~clock;

    // u_dut1 signals
    logic        if_req, if_gnt, if_rvalid;
    logic [63:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [63:0] dm_addr, dm_wdata, dm_rdata;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    // u_dut3 signals
    logic        if_req3, if_gnt3, if_rvalid3;
    logic [63:0] if_addr3, if_rdata3;
    logic        dm_req3, dm_we3, dm_gnt3, dm_rvalid3;
    logic [63:0] dm_addr3, dm_wdata3, dm_rdata3;
    logic [63:0] mem_addr3, mem_wdata3, mem_rdata3;
    logic        mem_we3;

    // Memory contents: explicit literals for every address the bench reads.
    function automatic logic [63:0] mem_fn(input logic [63:0] a);
        case (a)
            64'h40:  return 64'h0000_0000_0050_0093;
            64'h44:  return 64'h0000_0000_00A0_0113;
            64'h48:  return 64'h0000_0000_FFFF_FFFF;
            64'h100: return 64'h1111_2222_3333_4444;
            64'h200: return 64'hCAFE_F00D_0000_0001;
            64'h300: return 64'h8000_0000_0000_0000;
            default: return 64'hBAD0_BAD0_BAD0_BAD0;
        endcase
    endfunction
    assign mem_rdata = mem_fn(mem_addr);

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1)) u_dut1 (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(3)) u_dut3 (
        .clock(clock), .reset(reset),
        .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3),
        .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
        .dm_req(dm_req3), .dm_we(dm_we3), .dm_addr(dm_addr3), .dm_wdata(dm_wdata3),
        .dm_gnt(dm_gnt3), .dm_rvalid(dm_rvalid3), .dm_rdata(dm_rdata3),
        .mem_addr(mem_addr3), .mem_we(mem_we3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata3)
    );

    typedef struct {
        logic        if_req;
        logic [63:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [63:0] dm_addr;
        logic [63:0] dm_wdata;
        logic [63:0] exp_if_rdata;
        logic [63:0] exp_dm_rdata;
    } vec_t;

    typedef struct {
        logic        dm;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
    } ex_t;

    typedef struct {
        logic        dm;
        logic [63:0] rdata;
        int          cyc;
    } rs_t;

    ex_t gnt_q[$];
    rs_t rsp_q[$];
    int  gnt_cycs[$];
    int  cyc;
    int  n_tests;
    int  n_fail;
`ifdef ARB_RR_EN
    logic rr_last_dm;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event not expected by scoreboard (cycle %0d)", name, cyc);
    endtask

    // One clock: sample at the falling edge and run the scoreboard on u_dut1.
    task automatic step();
        ex_t e;
        rs_t r;
        @(negedge clock);
        cyc++;
        chk("gnt_excl", 64'(if_gnt & dm_gnt), 64'd0);
        chk("rvalid_excl", 64'(if_rvalid & dm_rvalid), 64'd0);
        chk("we_only_issue", 64'(mem_we & ~(if_gnt | dm_gnt)), 64'd0);
        if (if_gnt || dm_gnt) begin
            gnt_cycs.push_back(cyc);
            if (gnt_q.size() == 0) begin
                note_fail("unexpected_gnt");
            end else begin
                e = gnt_q.pop_front();
                chk("gnt_owner", 64'(dm_gnt), 64'(e.dm));
                chk("mem_addr", mem_addr, e.addr);
                chk("mem_we", 64'(mem_we), 64'(e.we));
                if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
                r.dm = e.dm; r.rdata = e.rdata; r.cyc = cyc;
                rsp_q.push_back(r);
            end
        end
        if (if_rvalid || dm_rvalid) begin
            if (rsp_q.size() == 0) begin
                note_fail("unexpected_rvalid");
            end else begin
                r = rsp_q.pop_front();
                chk("rvalid_owner", 64'(dm_rvalid), 64'(r.dm));
                chk("rvalid_latency", 64'(cyc - r.cyc), 64'd2);
                if (r.dm) chk("dm_rdata", dm_rdata, r.rdata);
                else      chk("if_rdata", if_rdata, r.rdata);
            end
        end
    endtask

    task automatic push_if(input logic [63:0] a, input logic [63:0] rd);
        ex_t e;
        e.dm = 1'b0; e.we = 1'b0; e.addr = a; e.wdata = 64'd0; e.rdata = rd;
        gnt_q.push_back(e);
    endtask

    task automatic push_dm(input logic we, input logic [63:0] a, input logic [63:0] wd,
                           input logic [63:0] rd);
        ex_t e;
        e.dm = 1'b1; e.we = we; e.addr = a; e.wdata = wd; e.rdata = rd;
        gnt_q.push_back(e);
    endtask

    // Run until the scoreboard drains; hold_gnts>0 keeps both requests high
    // until that many grants have been seen.
    task automatic run(input int hold_gnts);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            step();
            if (hold_gnts == 0) begin
                if (if_gnt) if_req = 1'b0;
                if (dm_gnt) dm_req = 1'b0;
            end else if (gnt_cycs.size() >= hold_gnts) begin
                if_req = 1'b0;
                dm_req = 1'b0;
            end
            if (gnt_q.size() == 0 && rsp_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            note_fail("drain_timeout");
            gnt_q.delete();
            rsp_q.delete();
            if_req = 1'b0;
            dm_req = 1'b0;
        end
    endtask

    vec_t vecs[7];

    initial begin
        vec_t v;
        logic dm_first;
        int   start;
        n_tests = 0; n_fail = 0; cyc = 0;
`ifdef ARB_RR_EN
        rr_last_dm = 1'b0;
`endif
        //            if_req if_addr  dm_req we  dm_addr   dm_wdata   exp_if_rdata            exp_dm_rdata
        vecs[0] = '{1'b1, 64'h40, 1'b0, 1'b0, 64'h0,   64'h0,     64'h0000_0000_0050_0093, 64'h0};
        vecs[1] = '{1'b0, 64'h0,  1'b1, 1'b1, 64'h100, 64'hDEAD,  64'h0,                   64'h0};
        vecs[2] = '{1'b0, 64'h0,  1'b1, 1'b0, 64'h100, 64'h0,     64'h0,                   64'h1111_2222_3333_4444};
        vecs[3] = '{1'b1, 64'h44, 1'b1, 1'b0, 64'h200, 64'h0,     64'h0000_0000_00A0_0113, 64'hCAFE_F00D_0000_0001};
        vecs[4] = '{1'b1, 64'h48, 1'b1, 1'b1, 64'h300, 64'h55,    64'h0000_0000_FFFF_FFFF, 64'hCAFE_F00D_0000_0001};
        vecs[5] = '{1'b0, 64'h0,  1'b1, 1'b0, 64'h300, 64'h0,     64'h0,                   64'h8000_0000_0000_0000};
        vecs[6] = '{1'b1, 64'h40, 1'b1, 1'b0, 64'h100, 64'h0,     64'h0000_0000_0050_0093, 64'h1111_2222_3333_4444};

        reset = 1'b1;
        if_req = 1'b0; if_addr = 64'd0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = 64'd0; dm_wdata = 64'd0;
        if_req3 = 1'b0; if_addr3 = 64'd0; dm_req3 = 1'b0; dm_we3 = 1'b0; dm_addr3 = 64'd0;
        dm_wdata3 = 64'd0; mem_rdata3 = 64'hDEAD_DEAD_DEAD_DEAD;

        // Reset state
        step();
        step();
        chk("rst_if_rdata", if_rdata, 64'd0);
        chk("rst_dm_rdata", dm_rdata, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_pulses", 64'({if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_we}), 64'd0);
        chk("rst_dut3_pulses", 64'({if_gnt3, dm_gnt3, if_rvalid3, dm_rvalid3, mem_we3}), 64'd0);
        reset = 1'b0;

        // Vector table on the MEM_LAT=1 instance
        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            step();
            gnt_cycs.delete();
            if_req = v.if_req; if_addr = v.if_addr;
            dm_req = v.dm_req; dm_we = v.dm_we; dm_addr = v.dm_addr; dm_wdata = v.dm_wdata;
            start = cyc;
            dm_first = v.dm_req;
            if (v.if_req && v.dm_req) begin
`ifdef ARB_RR_EN
                dm_first = ~rr_last_dm;
                rr_last_dm = dm_first;
`else
                dm_first = 1'b1;
`endif
            end
            if (v.dm_req && dm_first) push_dm(v.dm_we, v.dm_addr, v.dm_wdata, v.exp_dm_rdata);
            if (v.if_req) push_if(v.if_addr, v.exp_if_rdata);
            if (v.dm_req && !dm_first) push_dm(v.dm_we, v.dm_addr, v.dm_wdata, v.exp_dm_rdata);
            run(0);
            if (gnt_cycs.size() > 0) chk("first_gnt_latency", 64'(gnt_cycs[0] - start), 64'd1);
            if (gnt_cycs.size() == 2) chk("b2b_gnt_spacing", 64'(gnt_cycs[1] - gnt_cycs[0]), 64'd3);
        end

        // MEM_LAT=3 load: memory data valid only in the third WAIT cycle
        step();
        dm_req3 = 1'b1; dm_we3 = 1'b0; dm_addr3 = 64'h8;
        step();
        chk("l3_gnt", 64'(dm_gnt3), 64'd1);
        chk("l3_issue_addr", mem_addr3, 64'h8);
        chk("l3_issue_we", 64'(mem_we3), 64'd0);
        dm_req3 = 1'b0;
        dm_addr3 = 64'hFFFF;
        for (int w = 1; w <= 3; w++) begin
            if (w == 3) begin
                @(posedge clock);
                #1 mem_rdata3 = 64'h0123_4567_89AB_CDEF;
            end
            step();
            chk("l3_wait_addr", mem_addr3, 64'h8);
            chk("l3_wait_we", 64'(mem_we3), 64'd0);
            chk("l3_no_early_rvalid", 64'(dm_rvalid3 | dm_gnt3), 64'd0);
        end
        @(posedge clock);
        #1 mem_rdata3 = 64'hDEAD_DEAD_DEAD_DEAD;
        step();
        chk("l3_rvalid", 64'(dm_rvalid3), 64'd1);
        chk("l3_rdata", dm_rdata3, 64'h0123_4567_89AB_CDEF);
        step();
        chk("l3_rvalid_pulse", 64'(dm_rvalid3), 64'd0);

        // Reset during ISSUE of a store
        step();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h300; dm_wdata = 64'h77;
        push_dm(1'b1, 64'h300, 64'h77, 64'd0);
        step();
        chk("rst_issue_we_hi", 64'(mem_we), 64'd1);
        dm_req = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_async_we", 64'(mem_we), 64'd0);
        chk("rst_async_gnt", 64'(dm_gnt), 64'd0);
        chk("rst_async_dm_rdata", dm_rdata, 64'd0);
        chk("rst_async_if_rdata", if_rdata, 64'd0);
        gnt_q.delete();
        rsp_q.delete();
        step();
        step();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rst_no_rvalid", 64'(dm_rvalid), 64'd0);
        end
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h200;
        push_dm(1'b0, 64'h200, 64'd0, 64'hCAFE_F00D_0000_0001);
        run(0);

        // Both requests held continuously for four accesses
        step();
        gnt_cycs.delete();
        if_req = 1'b1; if_addr = 64'h44;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h200;
`ifdef ARB_RR_EN
        push_dm(1'b0, 64'h200, 64'd0, 64'hCAFE_F00D_0000_0001);
        push_if(64'h44, 64'h0000_0000_00A0_0113);
        push_dm(1'b0, 64'h200, 64'd0, 64'hCAFE_F00D_0000_0001);
        push_if(64'h44, 64'h0000_0000_00A0_0113);
`else
        for (int k = 0; k < 4; k++) push_dm(1'b0, 64'h200, 64'd0, 64'hCAFE_F00D_0000_0001);
`endif
        run(4);
        chk("held_gnt_count", 64'(gnt_cycs.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("held_idle_after", 64'(if_gnt | dm_gnt | if_rvalid | dm_rvalid), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
